// File: rtl/hbram_burst_engine.sv
// HyperRAM burst engine: turns one sequencer request into a single command plus
// burst_len data beats on the HyperBus controller native interface.
module hbram_burst_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  ram_clock,
  input  logic                  ram_reset_n,
  input  logic                  ram_en,
  input  logic                  ram_rw_ctrl,
  input  logic [31:0]           ram_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  operating,
  output logic                  busy,
  output logic                  hbc_cmd_valid,
  input  logic                  hbc_cmd_ready,
  output logic                  hbc_cmd_rw,
  output logic [31:0]           hbc_cmd_addr,
  output logic [LEN_WIDTH-1:0]  hbc_cmd_len,
  output logic                  hbc_wr_valid,
  input  logic                  hbc_wr_ready,
  output logic [DATA_WIDTH-1:0] hbc_wr_data,
  output logic                  hbc_wr_last,
  input  logic                  hbc_rd_valid,
  input  logic [DATA_WIDTH-1:0] hbc_rd_data,
  output logic                  wfifo_rd_en,
  input  logic [DATA_WIDTH-1:0] wfifo_rd_data,
  input  logic                  wfifo_empty,
  output logic                  rfifo_wr_en,
  output logic [DATA_WIDTH-1:0] rfifo_wr_data,
  input  logic                  rfifo_full,
  output logic                  err_overflow
);

  // state | meaning
  // IDLE  | no burst, waiting for ram_en
  // CMD   | presenting the latched command to the controller
  // WDATA | streaming write FIFO beats to the controller
  // RDATA | streaming controller read beats into the read FIFO
  // DONE  | single-cycle gap; starts a pending/new burst or returns to IDLE
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic                 pending, pending_nxt;
  logic                 rw, rw_nxt;
  logic [31:0]          addr, addr_nxt;
  logic [LEN_WIDTH-1:0] len, len_nxt;
  logic [LEN_WIDTH-1:0] cnt, cnt_nxt;
  logic                 err, err_nxt;

  logic                 latch_req;
  logic                 at_last;
  logic                 cmd_valid_c, wr_valid_c, wr_last_c, pop_c, push_c;

  assign at_last = (cnt == (len - LEN_ONE));

  always_ff @(posedge ram_clock) begin
    if (!ram_reset_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      rw      <= 1'b0;
      addr    <= '0;
      len     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      rw      <= rw_nxt;
      addr    <= addr_nxt;
      len     <= len_nxt;
      cnt     <= cnt_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    rw_nxt        = rw;
    addr_nxt      = addr;
    len_nxt       = len;
    cnt_nxt       = cnt;
    err_nxt       = err;
    latch_req     = 1'b0;
    operating     = 1'b0;
    cmd_valid_c   = 1'b0;
    wr_valid_c    = 1'b0;
    wr_last_c     = 1'b0;
    pop_c         = 1'b0;
    push_c        = 1'b0;
    hbc_wr_data   = '0;
    rfifo_wr_data = '0;

    case (state)
      IDLE: begin
        if (ram_en) begin
          latch_req = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        operating   = 1'b1;
        cmd_valid_c = 1'b1;
        if (ram_en) pending_nxt = 1'b1;
        if (hbc_cmd_ready) begin
          cnt_nxt   = '0;
          state_nxt = rw ? RDATA : WDATA;
        end
      end
      WDATA: begin
        operating   = 1'b1;
        if (ram_en) pending_nxt = 1'b1;
        wr_valid_c  = ~wfifo_empty;
        hbc_wr_data = wfifo_rd_data;
        wr_last_c   = wr_valid_c & at_last;
        if (wr_valid_c && hbc_wr_ready) begin
          pop_c   = 1'b1;
          cnt_nxt = cnt + LEN_ONE;
          if (at_last) state_nxt = DONE;
        end
      end
      RDATA: begin
        operating     = 1'b1;
        if (ram_en) pending_nxt = 1'b1;
        rfifo_wr_data = hbc_rd_data;
        if (hbc_rd_valid) begin
          // a beat arriving into a full FIFO is lost but still counted
          push_c  = ~rfifo_full;
          cnt_nxt = cnt + LEN_ONE;
          if (rfifo_full) err_nxt = 1'b1;
          if (at_last) state_nxt = DONE;
        end
      end
      DONE: begin
        if (pending || ram_en) begin
          latch_req   = 1'b1;
          pending_nxt = 1'b0;
          state_nxt   = CMD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (latch_req) begin
      rw_nxt   = ram_rw_ctrl;
      addr_nxt = ram_addr;
      len_nxt  = (burst_len == '0) ? LEN_ONE : burst_len;
    end
  end

  // Handshakes are gated by reset so an abandoned burst pops/pushes nothing more.
  assign hbc_cmd_valid = cmd_valid_c & ram_reset_n;
  assign hbc_wr_valid  = wr_valid_c & ram_reset_n;
  assign hbc_wr_last   = wr_last_c & ram_reset_n;
  assign wfifo_rd_en   = pop_c & ram_reset_n;
  assign rfifo_wr_en   = push_c & ram_reset_n;

  assign busy          = (state != IDLE);
  assign hbc_cmd_rw    = rw;
  assign hbc_cmd_addr  = addr;
  assign hbc_cmd_len   = len;
  assign err_overflow  = err;

endmodule

// File: tb/tb_hbram_burst_engine.sv
// Directed bench for hbram_burst_engine: models a first-word-fall-through write
// FIFO, drives read beats by hand and checks outputs against fixed expectations.
module tb_hbram_burst_engine;

  logic        clk;
  logic        ram_reset_n;
  logic        ram_en;
  logic        ram_rw_ctrl;
  logic [31:0] ram_addr;
  logic [10:0] burst_len;
  logic        operating, busy;
  logic        hbc_cmd_valid, hbc_cmd_ready, hbc_cmd_rw;
  logic [31:0] hbc_cmd_addr;
  logic [10:0] hbc_cmd_len;
  logic        hbc_wr_valid, hbc_wr_ready, hbc_wr_last;
  logic [31:0] hbc_wr_data;
  logic        hbc_rd_valid;
  logic [31:0] hbc_rd_data;
  logic        wfifo_rd_en, wfifo_empty;
  logic [31:0] wfifo_rd_data;
  logic        rfifo_wr_en, rfifo_full;
  logic [31:0] rfifo_wr_data;
  logic        err_overflow;

  int checks = 0;
  int failures = 0;

  logic [31:0] wmem [0:31];
  logic [4:0]  whead = '0;
  logic [4:0]  wtail = '0;
  logic        force_empty;

  int pops = 0, nwr = 0, pushes = 0, rises = 0;
  logic op_prev = 1'b0;
  logic [31:0] plog [0:63];
  int base_a, base_b;

  hbram_burst_engine dut (
    .ram_clock(clk), .ram_reset_n(ram_reset_n), .ram_en(ram_en),
    .ram_rw_ctrl(ram_rw_ctrl), .ram_addr(ram_addr), .burst_len(burst_len),
    .operating(operating), .busy(busy),
    .hbc_cmd_valid(hbc_cmd_valid), .hbc_cmd_ready(hbc_cmd_ready),
    .hbc_cmd_rw(hbc_cmd_rw), .hbc_cmd_addr(hbc_cmd_addr), .hbc_cmd_len(hbc_cmd_len),
    .hbc_wr_valid(hbc_wr_valid), .hbc_wr_ready(hbc_wr_ready),
    .hbc_wr_data(hbc_wr_data), .hbc_wr_last(hbc_wr_last),
    .hbc_rd_valid(hbc_rd_valid), .hbc_rd_data(hbc_rd_data),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data), .wfifo_empty(wfifo_empty),
    .rfifo_wr_en(rfifo_wr_en), .rfifo_wr_data(rfifo_wr_data), .rfifo_full(rfifo_full),
    .err_overflow(err_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign wfifo_rd_data = wmem[whead];
  assign wfifo_empty   = (whead == wtail) || force_empty;

  always @(posedge clk) begin
    if (wfifo_rd_en) begin
      whead <= whead + 5'd1;
      pops  <= pops + 1;
    end
    if (hbc_wr_valid && hbc_wr_ready) nwr <= nwr + 1;
    if (rfifo_wr_en) begin
      plog[pushes[5:0]] <= rfifo_wr_data;
      pushes <= pushes + 1;
    end
    if (operating && !op_prev) rises <= rises + 1;
    op_prev <= operating;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [31:0] d);
    wmem[wtail] = d;
    wtail = wtail + 5'd1;
  endtask

  task automatic req(input logic rw, input logic [31:0] a, input logic [10:0] l);
    ram_en      = 1'b1;
    ram_rw_ctrl = rw;
    ram_addr    = a;
    burst_len   = l;
  endtask

  initial begin
    ram_reset_n   = 1'b0;
    ram_en        = 1'b0;
    ram_rw_ctrl   = 1'b0;
    ram_addr      = '0;
    burst_len     = '0;
    hbc_cmd_ready = 1'b1;
    hbc_wr_ready  = 1'b1;
    hbc_rd_valid  = 1'b0;
    hbc_rd_data   = '0;
    rfifo_full    = 1'b0;
    force_empty   = 1'b0;
    cyc(); cyc(); #1;
    chk("rst_operating", operating, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", hbc_cmd_valid, 0);
    chk("rst_err", err_overflow, 0);
    chk("rst_wr_valid", hbc_wr_valid, 0);
    chk("rst_wfifo_rd_en", wfifo_rd_en, 0);
    chk("rst_rfifo_wr_en", rfifo_wr_en, 0);
    ram_reset_n = 1'b1;

    // write burst of 4, ready always high
    for (int i = 0; i < 4; i++) push_w(32'hA0 + i);
    base_a = pops; base_b = nwr;
    req(1'b0, 32'h100, 11'd4);
    cyc(); ram_en = 1'b0; #1;
    chk("w4_cmd_valid", hbc_cmd_valid, 1);
    chk("w4_cmd_addr", hbc_cmd_addr, 32'h100);
    chk("w4_cmd_len", hbc_cmd_len, 4);
    chk("w4_cmd_rw", hbc_cmd_rw, 0);
    chk("w4_op_cmd", operating, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      chk("w4_wr_valid", hbc_wr_valid, 1);
      chk("w4_wr_data", hbc_wr_data, 32'hA0 + k);
      chk("w4_wr_last", hbc_wr_last, (k == 3) ? 1 : 0);
      chk("w4_op_data", operating, 1);
    end
    cyc(); #1;
    chk("w4_done_op", operating, 0);
    chk("w4_done_busy", busy, 1);
    cyc(); #1;
    chk("w4_idle_busy", busy, 0);
    chk("w4_pops", pops - base_a, 4);
    chk("w4_beats", nwr - base_b, 4);

    // read burst of 4 with one gap cycle
    base_a = pushes;
    req(1'b1, 32'h200, 11'd4);
    cyc(); ram_en = 1'b0; #1;
    chk("r4_cmd_rw", hbc_cmd_rw, 1);
    cyc(); hbc_rd_valid = 1'b1; hbc_rd_data = 32'hB0; #1;
    chk("r4_push0", rfifo_wr_en, 1);
    chk("r4_data0", rfifo_wr_data, 32'hB0);
    cyc(); hbc_rd_data = 32'hB1; #1;
    chk("r4_push1", rfifo_wr_en, 1);
    cyc(); hbc_rd_valid = 1'b0; #1;
    chk("r4_gap_push", rfifo_wr_en, 0);
    chk("r4_gap_op", operating, 1);
    cyc(); hbc_rd_valid = 1'b1; hbc_rd_data = 32'hB2; #1;
    cyc(); hbc_rd_data = 32'hB3; #1;
    chk("r4_data3", rfifo_wr_data, 32'hB3);
    cyc(); hbc_rd_valid = 1'b0; #1;
    chk("r4_done_op", operating, 0);
    chk("r4_done_busy", busy, 1);
    cyc(); #1;
    chk("r4_pushes", pushes - base_a, 4);
    chk("r4_plog0", plog[base_a[5:0]], 32'hB0);
    chk("r4_plog3", plog[base_a[5:0] + 6'd3], 32'hB3);
    chk("r4_err", err_overflow, 0);

    // command held while ready is low for 3 cycles
    push_w(32'hC0);
    base_a = rises;
    hbc_cmd_ready = 1'b0;
    req(1'b0, 32'h300, 11'd1);
    cyc(); ram_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_cmd_valid", hbc_cmd_valid, 1);
      chk("stall_cmd_addr", hbc_cmd_addr, 32'h300);
      chk("stall_cmd_len", hbc_cmd_len, 1);
      cyc();
    end
    hbc_cmd_ready = 1'b1; #1;
    chk("stall_cmd_addr4", hbc_cmd_addr, 32'h300);
    cyc(); #1;
    chk("stall_wr_data", hbc_wr_data, 32'hC0);
    chk("stall_wr_last", hbc_wr_last, 1);
    cyc(); cyc(); #1;
    chk("stall_rises", rises - base_a, 1);

    // write FIFO empty for two cycles mid-burst
    for (int i = 0; i < 4; i++) push_w(32'hD0 + i);
    base_a = pops; base_b = nwr;
    req(1'b0, 32'h600, 11'd4);
    cyc(); ram_en = 1'b0;
    cyc(); #1;
    chk("empty_d0", hbc_wr_data, 32'hD0);
    cyc(); #1;
    chk("empty_d1", hbc_wr_data, 32'hD1);
    cyc(); force_empty = 1'b1; #1;
    chk("empty_valid_a", hbc_wr_valid, 0);
    chk("empty_pop_a", wfifo_rd_en, 0);
    cyc(); #1;
    chk("empty_valid_b", hbc_wr_valid, 0);
    chk("empty_pop_b", wfifo_rd_en, 0);
    cyc(); force_empty = 1'b0; #1;
    chk("empty_d2", hbc_wr_data, 32'hD2);
    chk("empty_last2", hbc_wr_last, 0);
    cyc(); #1;
    chk("empty_d3", hbc_wr_data, 32'hD3);
    chk("empty_last3", hbc_wr_last, 1);
    cyc(); cyc(); #1;
    chk("empty_pops", pops - base_a, 4);
    chk("empty_beats", nwr - base_b, 4);

    // request pulsed during WDATA becomes the next burst
    push_w(32'hE0); push_w(32'hE1); push_w(32'hE2);
    base_a = rises;
    req(1'b0, 32'h100, 11'd2);
    cyc(); ram_en = 1'b0;
    cyc(); ram_en = 1'b1; ram_addr = 32'h140; burst_len = 11'd1; #1;
    chk("pend_e0", hbc_wr_data, 32'hE0);
    cyc(); ram_en = 1'b0; #1;
    chk("pend_last1", hbc_wr_last, 1);
    cyc(); #1;
    chk("pend_done_op", operating, 0);
    cyc(); #1;
    chk("pend_cmd_addr", hbc_cmd_addr, 32'h140);
    chk("pend_cmd_len", hbc_cmd_len, 1);
    chk("pend_cmd_op", operating, 1);
    cyc(); #1;
    chk("pend_e2", hbc_wr_data, 32'hE2);
    chk("pend_last2", hbc_wr_last, 1);
    cyc(); cyc(); #1;
    chk("pend_rises", rises - base_a, 2);
    chk("pend_idle_busy", busy, 0);

    // read of 2 with the read FIFO full on the second beat
    base_a = pushes;
    req(1'b1, 32'h400, 11'd2);
    cyc(); ram_en = 1'b0;
    cyc(); hbc_rd_valid = 1'b1; hbc_rd_data = 32'hF0; #1;
    chk("ovf_push0", rfifo_wr_en, 1);
    chk("ovf_err0", err_overflow, 0);
    cyc(); hbc_rd_data = 32'hF1; rfifo_full = 1'b1; #1;
    chk("ovf_push1", rfifo_wr_en, 0);
    cyc(); hbc_rd_valid = 1'b0; rfifo_full = 1'b0; #1;
    chk("ovf_err_set", err_overflow, 1);
    chk("ovf_done_op", operating, 0);
    cyc(); cyc(); #1;
    chk("ovf_err_held", err_overflow, 1);
    chk("ovf_pushes", pushes - base_a, 1);

    // burst_len of zero runs as a single beat
    push_w(32'h77);
    req(1'b0, 32'h500, 11'd0);
    cyc(); ram_en = 1'b0; #1;
    chk("len0_cmd_len", hbc_cmd_len, 1);
    cyc(); #1;
    chk("len0_wr_data", hbc_wr_data, 32'h77);
    chk("len0_wr_last", hbc_wr_last, 1);
    cyc(); cyc(); #1;
    chk("len0_idle_busy", busy, 0);

    // reset in the middle of a write burst
    push_w(32'h11); push_w(32'h22);
    base_a = pops;
    req(1'b0, 32'h700, 11'd4);
    cyc(); ram_en = 1'b0;
    cyc(); #1;
    chk("mrst_beat0_valid", hbc_wr_valid, 1);
    cyc(); ram_reset_n = 1'b0; #1;
    chk("mrst_pop_gated", wfifo_rd_en, 0);
    chk("mrst_last_gated", hbc_wr_last, 0);
    cyc(); #1;
    chk("mrst_operating", operating, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cmd_valid", hbc_cmd_valid, 0);
    chk("mrst_err", err_overflow, 0);
    chk("mrst_wr_valid", hbc_wr_valid, 0);
    chk("mrst_cmd_addr", hbc_cmd_addr, 0);
    chk("mrst_pops", pops - base_a, 1);
    ram_reset_n = 1'b1;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
